adc_clock_reconf_seq: RTL and testbench



---
 rtl/adc_clock_reconf_seq_if.sv | 45 ++++
 rtl/adc_clock_reconf_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_clock_reconf_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_clock_reconf_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_clock_reconf_seq_if                                   |
// | Brief    : AXI4-Lite master bus between the reconfiguration         |
// |            sequencer and the clocking wizard register port.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface adc_clock_reconf_seq_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/adc_clock_reconf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_clock_reconf_seq                                      |
// | Brief    : Writes the clocking wizard reconfiguration registers over |
// |            AXI4-Lite, issues LOAD and polls status until lock.       |
// |            Optional readback check: ADC_CLOCK_RECONF_VERIFY_EN.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module adc_clock_reconf_seq #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned LOCK_TIMEOUT = 1_000_000,
  parameter int unsigned POLL_GAP     = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       cfg_start,
  input  wire logic [7:0] cfg_divclk,
  input  wire logic [7:0] cfg_mult,
  input  wire logic [7:0] cfg_div0,
  input  wire logic [7:0] cfg_div1,
  input  wire logic [7:0] cfg_div2,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      err_code,
  adc_clock_reconf_seq_if.master m_axi
);

  localparam logic [31:0] STAT_OFF = 32'h004;
  localparam logic [31:0] GAP_INIT = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAIT_B, S_GAP, S_RD, S_WAIT_R
  } state_t;

  // Register offset for write-list slot i (slot 4 is the LOAD command)
  function automatic logic [31:0] reg_off(input logic [2:0] i);
    case (i)
      3'd0:    reg_off = 32'h200;
      3'd1:    reg_off = 32'h208;
      3'd2:    reg_off = 32'h214;
      3'd3:    reg_off = 32'h220;
      default: reg_off = 32'h25C;
    endcase
  endfunction

  // Register value for write-list slot i
  function automatic logic [31:0] reg_val(input logic [2:0] i, input logic [7:0] dc,
                                          input logic [7:0] m, input logic [7:0] d0,
                                          input logic [7:0] d1, input logic [7:0] d2);
    case (i)
      3'd0:    reg_val = {16'h0, m, dc};
      3'd1:    reg_val = {24'h0, d0};
      3'd2:    reg_val = {24'h0, d1};
      3'd3:    reg_val = {24'h0, d2};
      default: reg_val = 32'h3;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        rd_verify_q, rd_verify_d;
  logic [7:0]  divclk_q, divclk_d, mult_q, mult_d;
  logic [7:0]  div0_q, div0_d, div1_q, div1_d, div2_q, div2_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] tmo_q, tmo_d, gap_q, gap_d;

  logic        do_wr, do_rd, fail;
  logic [2:0]  wr_idx, fail_code;
  logic [31:0] rd_addr;
  logic        polling, tmo_expired;

  // Lock timer runs only while polling status after the LOAD write
  assign polling     = (state_q == S_GAP || state_q == S_RD || state_q == S_WAIT_R) && !rd_verify_q;
  assign tmo_expired = (tmo_q >= LOCK_TIMEOUT);

`ifdef ADC_CLOCK_RECONF_VERIFY_EN
  logic [31:0] rb_exp;
  logic        rb_mismatch;
  assign rb_exp      = reg_val(idx_q, divclk_q, mult_q, div0_q, div1_q, div2_q);
  // Only the bits actually written are meaningful on readback
  assign rb_mismatch = (idx_q == 3'd0) ? (m_axi.rdata[15:0] != rb_exp[15:0])
                                       : (m_axi.rdata[7:0] != rb_exp[7:0]);
`endif

  // Sequencer next-state and next-output logic
  always_comb begin
    state_d = state_q;   idx_d = idx_q;       rd_verify_d = rd_verify_q;
    divclk_d = divclk_q; mult_d = mult_q;
    div0_d = div0_q;     div1_d = div1_q;     div2_d = div2_q;
    busy_d = busy_q;     done_d = 1'b0;       err_d = 1'b0;    err_code_d = err_code_q;
    awaddr_d = awaddr_q; wdata_d = wdata_q;   araddr_d = araddr_q;
    awvalid_d = awvalid_q; wvalid_d = wvalid_q; bready_d = bready_q;
    arvalid_d = arvalid_q; rready_d = rready_q;
    tmo_d = tmo_q;       gap_d = gap_q;
    do_wr = 1'b0; wr_idx = idx_q; do_rd = 1'b0; rd_addr = araddr_q;
    fail = 1'b0;  fail_code = 3'd0;

    if (polling && !tmo_expired) tmo_d = tmo_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          divclk_d = cfg_divclk; mult_d = cfg_mult;
          div0_d = cfg_div0; div1_d = cfg_div1; div2_d = cfg_div2;
          busy_d = 1'b1; err_code_d = 3'd0; rd_verify_d = 1'b0;
          do_wr = 1'b1; wr_idx = 3'd0;
        end
      end
      S_WR: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          if (m_axi.bresp != 2'b00) begin
            fail = 1'b1; fail_code = 3'd1;
          end else if (idx_q == 3'd4) begin
            tmo_d = 32'd0; gap_d = GAP_INIT; state_d = S_GAP;
          end
`ifdef ADC_CLOCK_RECONF_VERIFY_EN
          else if (idx_q == 3'd3) begin
            rd_verify_d = 1'b1; idx_d = 3'd0;
            do_rd = 1'b1; rd_addr = BASE_ADDR + reg_off(3'd0);
          end
`endif
          else begin
            do_wr = 1'b1; wr_idx = idx_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (tmo_expired) begin
          fail = 1'b1; fail_code = 3'd3;
        end else if (gap_q == 32'd0) begin
          do_rd = 1'b1; rd_addr = BASE_ADDR + STAT_OFF;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_RD: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0; rready_d = 1'b1; state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
`ifdef ADC_CLOCK_RECONF_VERIFY_EN
          if (rd_verify_q) begin
            if (m_axi.rresp != 2'b00) begin
              fail = 1'b1; fail_code = 3'd2;
            end else if (rb_mismatch) begin
              fail = 1'b1; fail_code = 3'd4;
            end else if (idx_q == 3'd3) begin
              rd_verify_d = 1'b0; do_wr = 1'b1; wr_idx = 3'd4;
            end else begin
              idx_d = idx_q + 3'd1;
              do_rd = 1'b1; rd_addr = BASE_ADDR + reg_off(idx_q + 3'd1);
            end
          end else begin
`else
          begin
`endif
            // A response arriving after the timeout is discarded
            if (tmo_expired) begin
              fail = 1'b1; fail_code = 3'd3;
            end else if (m_axi.rresp != 2'b00) begin
              fail = 1'b1; fail_code = 3'd2;
            end else if (m_axi.rdata[0]) begin
              done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
            end else begin
              gap_d = GAP_INIT; state_d = S_GAP;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_wr) begin
      idx_d     = wr_idx;
      awaddr_d  = BASE_ADDR + reg_off(wr_idx);
      wdata_d   = reg_val(wr_idx, divclk_d, mult_d, div0_d, div1_d, div2_d);
      awvalid_d = 1'b1; wvalid_d = 1'b1;
      state_d   = S_WR;
    end
    if (do_rd) begin
      araddr_d = rd_addr; arvalid_d = 1'b1; state_d = S_RD;
    end
    if (fail) begin
      err_d = 1'b1; err_code_d = fail_code; busy_d = 1'b0;
      rd_verify_d = 1'b0; state_d = S_IDLE;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  idx_q <= 3'd0;   rd_verify_q <= 1'b0;
      divclk_q <= 8'd0;   mult_q <= 8'd0;
      div0_q <= 8'd0;     div1_q <= 8'd0;  div2_q <= 8'd0;
      busy_q <= 1'b0;     done_q <= 1'b0;  err_q <= 1'b0;   err_code_q <= 3'd0;
      awaddr_q <= 32'd0;  wdata_q <= 32'd0; araddr_q <= 32'd0;
      awvalid_q <= 1'b0;  wvalid_q <= 1'b0; bready_q <= 1'b0;
      arvalid_q <= 1'b0;  rready_q <= 1'b0;
      tmo_q <= 32'd0;     gap_q <= 32'd0;
    end else begin
      state_q <= state_d;   idx_q <= idx_d;     rd_verify_q <= rd_verify_d;
      divclk_q <= divclk_d; mult_q <= mult_d;
      div0_q <= div0_d;     div1_q <= div1_d;   div2_q <= div2_d;
      busy_q <= busy_d;     done_q <= done_d;   err_q <= err_d;  err_code_q <= err_code_d;
      awaddr_q <= awaddr_d; wdata_q <= wdata_d; araddr_q <= araddr_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; bready_q <= bready_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;
      tmo_q <= tmo_d;       gap_q <= gap_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_clock_reconf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_adc_clock_reconf_seq                                   |
// | Brief    : Randomized bench for adc_clock_reconf_seq with an AXI4-   |
// |            Lite slave model and a transaction-list reference model.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_adc_clock_reconf_seq;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int TMO = 200;
  localparam int GAP = 16;

  logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0;
  logic [7:0] cfg_divclk = 8'd0, cfg_mult = 8'd0, cfg_div0 = 8'd0, cfg_div1 = 8'd0, cfg_div2 = 8'd0;
  logic busy, done, err;
  logic [2:0] err_code;

  adc_clock_reconf_seq_if bus ();

  adc_clock_reconf_seq #(.BASE_ADDR(BASE), .LOCK_TIMEOUT(TMO), .POLL_GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_divclk(cfg_divclk), .cfg_mult(cfg_mult),
    .cfg_div0(cfg_div0), .cfg_div1(cfg_div1), .cfg_div2(cfg_div2),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, lock_poll = 3;
  logic [31:0] err_addr = 32'd0, corrupt_addr = 32'd0;
  logic [1:0]  err_resp = 2'b10;
  logic [7:0]  corrupt_val = 8'd0;

  // Observations
  logic [31:0] obs_waddr[$], obs_wdata[$], obs_raddr[$];
  logic [31:0] mem[logic [31:0]];
  int stab_bad = 0, poll_cnt = 0, pcyc = 0, load_cyc = 0;

  // Reference expectations
  logic [31:0] exp_waddr[$], exp_wdata[$], exp_raddr[$];
  int exp_code;

  initial forever begin
    @(posedge clk);
    pcyc++;
  end

  // AXI4-Lite slave: decides its outputs on the falling edge; a handshake
  // is taken on the next rising edge when both sides are high.
  initial begin
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
    bit aw_done = 0, w_done = 0, ar_hs = 0, aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [31:0] cur_aw = 0, cur_w = 0, cur_r = 0, p_aw = 0, p_w = 0, p_ar = 0, v;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        aw_done = 0; w_done = 0; ar_hs = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
      end else begin
        if (aw_pend && (!bus.awvalid || bus.awaddr != p_aw)) stab_bad++;
        if (w_pend && (!bus.wvalid || bus.wdata != p_w)) stab_bad++;
        if (ar_pend && (!bus.arvalid || bus.araddr != p_ar)) stab_bad++;
        // write response
        bus.bvalid = 0; bus.bresp = 0;
        if (aw_done && w_done) begin
          if (b_cnt >= b_dly) begin
            bus.bvalid = 1;
            bus.bresp = (cur_aw == err_addr) ? err_resp : 2'b00;
            if (bus.bready) begin
              mem[cur_aw] = cur_w;
              if (cur_aw == BASE + 32'h25C) load_cyc = pcyc;
              aw_done = 0; w_done = 0; b_cnt = 0;
            end
          end else b_cnt++;
        end
        // read data
        bus.rvalid = 0;
        if (ar_hs) begin
          bus.rvalid = 1; bus.rdata = cur_r; bus.rresp = 2'b00;
          if (bus.rready) ar_hs = 0;
        end
        // write address
        bus.awready = 0; aw_pend = 0;
        if (bus.awvalid && !aw_done) begin
          if (aw_cnt >= aw_dly) begin
            bus.awready = 1; cur_aw = bus.awaddr; obs_waddr.push_back(bus.awaddr);
            aw_done = 1; aw_cnt = 0;
          end else begin
            aw_cnt++; aw_pend = 1; p_aw = bus.awaddr;
          end
        end
        // write data
        bus.wready = 0; w_pend = 0;
        if (bus.wvalid && !w_done) begin
          if (w_cnt >= w_dly) begin
            bus.wready = 1; cur_w = bus.wdata; obs_wdata.push_back(bus.wdata);
            w_done = 1; w_cnt = 0;
          end else begin
            w_cnt++; w_pend = 1; p_w = bus.wdata;
          end
        end
        // read address
        bus.arready = 0; ar_pend = 0;
        if (bus.arvalid && !ar_hs) begin
          if (ar_cnt >= ar_dly) begin
            bus.arready = 1; obs_raddr.push_back(bus.araddr);
            ar_hs = 1; ar_cnt = 0;
            cur_r = $urandom;
            if (bus.araddr == BASE + 32'h004) begin
              poll_cnt++;
              cur_r[0] = (lock_poll != 0) && (poll_cnt >= lock_poll);
            end else begin
              v = mem.exists(bus.araddr) ? mem[bus.araddr] : 32'd0;
              if (bus.araddr == BASE + 32'h200) cur_r[15:0] = v[15:0];
              else cur_r[7:0] = v[7:0];
              if (bus.araddr == corrupt_addr) cur_r[7:0] = corrupt_val;
            end
          end else begin
            ar_cnt++; ar_pend = 1; p_ar = bus.araddr;
          end
        end
      end
    end
  end

  // Reference model: the list of bus transactions and the outcome of one request
  task automatic model(input logic [7:0] dc, m, d0, d1, d2);
    logic [31:0] offs[4];
    logic [31:0] vals[4];
    offs = '{32'h200, 32'h208, 32'h214, 32'h220};
    vals = '{{16'h0, m, dc}, {24'h0, d0}, {24'h0, d1}, {24'h0, d2}};
    exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete();
    for (int i = 0; i < 4; i++) begin
      exp_waddr.push_back(BASE + offs[i]); exp_wdata.push_back(vals[i]);
      if (BASE + offs[i] == err_addr) begin exp_code = 1; return; end
    end
`ifdef ADC_CLOCK_RECONF_VERIFY_EN
    for (int i = 0; i < 4; i++) begin
      exp_raddr.push_back(BASE + offs[i]);
      if (BASE + offs[i] == corrupt_addr && corrupt_val != vals[i][7:0]) begin
        exp_code = 4; return;
      end
    end
`endif
    exp_waddr.push_back(BASE + 32'h25C); exp_wdata.push_back(32'h3);
    if (BASE + 32'h25C == err_addr) begin exp_code = 1; return; end
    if (lock_poll == 0) begin exp_code = 3; return; end
    for (int k = 0; k < lock_poll; k++) exp_raddr.push_back(BASE + 32'h004);
    exp_code = 0;
  endtask

  task automatic run_txn(input string nm, input logic [7:0] dc, m, d0, d1, d2);
    int n;
    logic got_done, got_err;
    logic [2:0] got_code;
    int err_cyc, lim;
    model(dc, m, d0, d1, d2);
    obs_waddr.delete(); obs_wdata.delete(); obs_raddr.delete();
    mem.delete(); stab_bad = 0; poll_cnt = 0;
    @(negedge clk);
    cfg_divclk = dc; cfg_mult = m; cfg_div0 = d0; cfg_div1 = d1; cfg_div2 = d2;
    cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    check({nm, "_start_busy"}, busy, 1);
    check({nm, "_start_valid"}, {bus.awvalid, bus.wvalid}, 2'b11);
    {cfg_divclk, cfg_mult, cfg_div0, cfg_div1} = $urandom;
    cfg_div2 = 8'($urandom);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      n++;
      cfg_start = (n == 3);
      if (done || err) break;
    end
    cfg_start = 0;
    check({nm, "_finished"}, n < 5000, 1);
    got_done = done; got_err = err; got_code = err_code; err_cyc = pcyc;
    @(negedge clk);
    check({nm, "_pulse_width"}, {done, err, busy}, 3'b000);
    check({nm, "_code_held"}, err_code, got_code);
    check({nm, "_done"}, got_done, exp_code == 0);
    check({nm, "_err"}, got_err, exp_code != 0);
    check({nm, "_err_code"}, got_code, exp_code);
    check({nm, "_wr_cnt"}, {obs_waddr.size(), obs_wdata.size()}, {exp_waddr.size(), exp_waddr.size()});
    lim = (obs_waddr.size() < exp_waddr.size()) ? obs_waddr.size() : exp_waddr.size();
    if (obs_wdata.size() < lim) lim = obs_wdata.size();
    for (int i = 0; i < lim; i++) begin
      check({nm, "_wr_addr"}, obs_waddr[i], exp_waddr[i]);
      check({nm, "_wr_data"}, obs_wdata[i], exp_wdata[i]);
    end
    if (exp_code == 3) begin
      check({nm, "_rd_cnt_min"}, obs_raddr.size() >= exp_raddr.size(), 1);
      for (int i = exp_raddr.size(); i < obs_raddr.size(); i++)
        check({nm, "_poll_addr"}, obs_raddr[i], BASE + 32'h004);
      check({nm, "_tmo_window"}, (err_cyc - load_cyc >= TMO + 1) && (err_cyc - load_cyc <= TMO + GAP + 8), 1);
    end else begin
      check({nm, "_rd_cnt"}, obs_raddr.size(), exp_raddr.size());
    end
    lim = (obs_raddr.size() < exp_raddr.size()) ? obs_raddr.size() : exp_raddr.size();
    for (int i = 0; i < lim; i++) check({nm, "_rd_addr"}, obs_raddr[i], exp_raddr[i]);
    check({nm, "_stable"}, stab_bad, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic knobs_default();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; lock_poll = 3;
    err_addr = 0; err_resp = 2'b10; corrupt_addr = 0; corrupt_val = 0;
  endtask

  initial begin
    int n;
    logic [31:0] offs_all[5];
    offs_all = '{32'h200, 32'h208, 32'h214, 32'h220, 32'h25C};
    knobs_default();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, err, err_code, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("rst_addr", {bus.awaddr, bus.araddr}, 0);
    check("rst_wdata", bus.wdata, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run_txn("nominal", 8'd1, 8'd10, 8'd5, 8'd10, 8'd20);

    knobs_default(); err_addr = BASE + 32'h208; err_resp = 2'b10;
    run_txn("wr_err", 8'd1, 8'd10, 8'd5, 8'd10, 8'd20);

    knobs_default(); aw_dly = 4; w_dly = 1;
    run_txn("backpressure", 8'd2, 8'd33, 8'd7, 8'd9, 8'd11);

    knobs_default(); lock_poll = 0;
    run_txn("timeout", 8'd3, 8'd40, 8'd4, 8'd8, 8'd16);

`ifdef ADC_CLOCK_RECONF_VERIFY_EN
    knobs_default(); corrupt_addr = BASE + 32'h208; corrupt_val = 8'h06;
    run_txn("verify", 8'd1, 8'd10, 8'd5, 8'd10, 8'd20);
`endif

    // Reset in WAIT_B of the 0x214 write
    knobs_default(); b_dly = 4;
    obs_waddr.delete(); obs_wdata.delete();
    @(negedge clk);
    cfg_divclk = 8'd1; cfg_mult = 8'd12; cfg_div0 = 8'd3; cfg_div1 = 8'd6; cfg_div2 = 8'd9;
    cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    n = 0;
    while (n < 200 && !(obs_waddr.size() >= 3 && obs_wdata.size() >= 3)) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached", n < 200, 1);
    @(negedge clk);
    check("midrst_in_wait_b", {bus.bready, bus.awvalid, bus.wvalid}, 3'b100);
    rst_n = 0;
    @(negedge clk);
    check("midrst_ctrl", {busy, done, err, err_code, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 0);
    check("midrst_addr", {bus.awaddr, bus.araddr}, 0);
    check("midrst_wdata", bus.wdata, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    knobs_default();
    run_txn("after_rst", 8'd1, 8'd12, 8'd3, 8'd6, 8'd9);

    // Randomized requests
    for (int t = 0; t < 8; t++) begin
      knobs_default();
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 2);  ar_dly = $urandom_range(0, 2);
      lock_poll = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) begin
        err_addr = BASE + offs_all[$urandom_range(0, 4)];
        err_resp = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      end
      run_txn("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
